jtag_dmi_master: RTL
====================

# jtag_dmi_master

Synthesizable JTAG bit-bang master that performs RISC-V DMI reads and writes on a target TAP. It turns the hand-written TCK/TMS/TDI sequences used in SoC simulation into a parametrised hardware engine. It sits between a simple request/response port and the four JTAG pins of a tinyriscv JTAG TAP or any other 1149.1 TAP. Width, IR encoding and TCK rate are generalised, and it adds IR caching, TDO capture and a decoded response.

## Interface
- ABITS, 6: DMI address width.
- DBITS, 32: DMI data width. Scan length is N = ABITS+DBITS+2.
- IR_LEN, 5: TAP instruction register length.
- IR_DMI, 5'b10001: IR value that selects the DMI register. It is shifted LSB first.
- TCK_DIV, 2: TCK half-period in clk cycles. Must be ≥1.
- IR_CACHE, 1: when 1, the IR scan is skipped once IR_DMI is loaded. When 0, the IR scan runs on every request.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  engine idle and able to accept.
- req_op  in  2  DMI op: 0 nop/read-result, 1 read, 2 write.
- req_addr  in  ABITS  DMI address.
- req_data  in  DBITS  DMI write data.
- rsp_valid  out  1  one-cycle pulse when a scan completes.
- rsp_op  out  2  captured bits [1:0] of the scan-out (DMI status).
- rsp_data  out  DBITS  captured bits [DBITS+1:2].
- rsp_addr  out  ABITS  captured bits [N-1:DBITS+2].
- busy  out  1  high whenever the FSM is not in IDLE.
- jtag_tck  out  1  TCK.
- jtag_tms  out  1  TMS.
- jtag_tdi  out  1  TDI.
- jtag_tdo  in  1  TDO. It is already synchronous to clk, or synchronised by the instantiator.

## Operation
- TCK generator:
  - A tick counter runs only when the FSM is not in IDLE.
  - Each JTAG step is one TCK period: TCK_DIV clk cycles low, then TCK_DIV clk cycles high.
  - TMS and TDI update on the first clk of the low phase.
  - TDO is sampled on the last clk of the low phase, before the rising edge.
- FSM states: TLR, IDLE, IR_HDR, IR_SHIFT, IR_TAIL, DR_HDR, DR_SHIFT, DR_TAIL, RSP.
- TLR:
  - Entered from reset.
  - Drives 8 steps with TMS=1, then 1 step with TMS=0 to reach Run-Test/Idle.
  - Clears ir_loaded, then goes to IDLE.
- IDLE:
  - req_ready=1, TCK held 0, TMS=0.
  - On req_valid&&req_ready, op/addr/data are registered into an N-bit shift word {addr,data,op}.
  - Goes to IR_HDR if (!IR_CACHE || !ir_loaded), otherwise to DR_HDR.
- IR_HDR: TMS 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
- IR_SHIFT:
  - IR_LEN steps, TDI = IR_DMI LSB first.
  - TMS=1 only on the last step.
- IR_TAIL: TMS 1,0 (Update-IR, then Run-Test/Idle). Sets ir_loaded.
- DR_HDR: TMS 1,0,0 (Select-DR, Capture-DR, Shift-DR).
- DR_SHIFT:
  - N steps, TDI = shift word bit 0.
  - TDO is shifted in at the MSB and the word shifts right each step.
  - TMS=1 only on the last step.
- DR_TAIL: TMS 1,0 (Update-DR, then Run-Test/Idle).
- RSP:
  - Drives the rsp_* fields from the captured word and pulses rsp_valid for one clk.
  - Returns to IDLE in the same cycle. req_ready is 1 in that cycle, so back-to-back requests are allowed.
- An op=0 request still performs a full DR scan. This is how the result of a previous read is collected.
- req_valid while busy is ignored. No request is queued.
- The step counter width is clog2(max(N,IR_LEN,9))+1. It counts down and never wraps.

## Timing
- Reset values:
  - jtag_tck=0, jtag_tms=1, jtag_tdi=0.
  - req_ready=0, rsp_valid=0, busy=1, rsp_op/rsp_data/rsp_addr=0.
  - State=TLR, ir_loaded=0.
- Reset to first req_ready: 9·2·TCK_DIV clk after rst is released.
- Request with IR scan: (6+IR_LEN) + (5+N) TCK periods from the acceptance edge to rsp_valid, where one TCK period is 2·TCK_DIV clk.
- Request without IR scan: (5+N) TCK periods.
- rsp_* fields hold their values until the next rsp_valid.
- rst asserted mid-scan: on the next clk all outputs take their reset values, and the engine redoes TLR and the IR scan. The aborted request produces no response.
- TCK_DIV=1: TCK toggles every clk. TDO is still sampled in the low cycle.

## Test plan
- Reset, TCK_DIV=2 -> exactly 9 TCK pulses, each 4 clk, with TMS=1,1,1,1,1,1,1,1,0; req_ready rises at clk 36; outputs before that are tck=0, tms=1, rsp_valid=0.
- Write op=2, addr=0x10, data=0 from IDLE -> TDI stream 0x4000000002 (40 bits, LSB first) after IR bits 1,0,0,0,1; rsp_valid at 224 clk after acceptance.
- Second request with IR_CACHE=1 -> no IR scan; rsp_valid 180 clk after acceptance. Same request with IR_CACHE=0 -> 224 clk.
- TAP bench model returning {6'h11, 32'hDEADBEEF, 2'b00} on Capture-DR -> rsp_addr=0x11, rsp_data=0xDEADBEEF, rsp_op=0. jtag_tdo tied to 1 -> rsp_addr=0x3F, rsp_data=0xFFFFFFFF, rsp_op=3.
- rst pulsed during DR_SHIFT bit 20 -> next clk outputs at reset values; no rsp_valid; TLR repeats; the next request includes an IR scan.
- req_valid held high while busy, and back-to-back requests -> only one acceptance per response; a new request is accepted in the rsp_valid cycle.

Source files
------------

// File: rtl/jtag_dmi_master.sv
// jtag_dmi_master: JTAG bit-bang master that runs RISC-V DMI scans on a TAP.
// Ports: clk/rst (sync, active high); req_* request in (op/addr/data,
//   valid/ready); rsp_* decoded DR capture with a one-cycle rsp_valid;
//   busy while not idle; jtag_tck/tms/tdi out, jtag_tdo in (clk-synchronous).
module jtag_dmi_master #(
  parameter int                ABITS    = 6,
  parameter int                DBITS    = 32,
  parameter int                IR_LEN   = 5,
  parameter logic [IR_LEN-1:0] IR_DMI   = 5'b10001,
  parameter int                TCK_DIV  = 2,
  parameter int                IR_CACHE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [ABITS-1:0] req_addr,
  input  logic [DBITS-1:0] req_data,
  output logic             rsp_valid,
  output logic [1:0]       rsp_op,
  output logic [DBITS-1:0] rsp_data,
  output logic [ABITS-1:0] rsp_addr,
  output logic             busy,
  output logic             jtag_tck,
  output logic             jtag_tms,
  output logic             jtag_tdi,
  input  logic             jtag_tdo
);

  localparam int N  = ABITS + DBITS + 2;
  localparam int M0 = (N > IR_LEN) ? N : IR_LEN;
  localparam int MX = (M0 > 9) ? M0 : 9;
  localparam int SW = $clog2(MX) + 1;
  localparam int TW = $clog2(2 * TCK_DIV) + 1;

  localparam logic [TW-1:0] T_LAST_LO = TW'(TCK_DIV - 1);
  localparam logic [TW-1:0] T_HI      = TW'(TCK_DIV);
  localparam logic [TW-1:0] T_LAST    = TW'(2 * TCK_DIV - 1);

  typedef enum logic [3:0] {
    S_TLR,
    S_IDLE,
    S_IR_HDR,
    S_IR_SHIFT,
    S_IR_TAIL,
    S_DR_HDR,
    S_DR_SHIFT,
    S_DR_TAIL,
    S_RSP
  } state_e;

  state_e             state_q, state_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [SW-1:0]      step_q, step_d;
  logic               ir_loaded_q, ir_loaded_d;
  logic [IR_LEN-1:0]  ir_q, ir_d;
  logic [N-1:0]       sh_q, sh_d;
  logic               tdo_q, tdo_d;
  logic [1:0]         rsp_op_q, rsp_op_d;
  logic [DBITS-1:0]   rsp_data_q, rsp_data_d;
  logic [ABITS-1:0]   rsp_addr_q, rsp_addr_d;

  logic active;
  logic step_end;
  logic last;
  logic adv;
  logic accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_TLR;
      tick_q      <= '0;
      step_q      <= SW'(8);
      ir_loaded_q <= 1'b0;
      ir_q        <= '0;
      sh_q        <= '0;
      tdo_q       <= 1'b0;
      rsp_op_q    <= '0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      step_q      <= step_d;
      ir_loaded_q <= ir_loaded_d;
      ir_q        <= ir_d;
      sh_q        <= sh_d;
      tdo_q       <= tdo_d;
      rsp_op_q    <= rsp_op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    ir_loaded_d = ir_loaded_q;
    ir_d        = ir_q;
    sh_d        = sh_q;
    tdo_d       = tdo_q;
    rsp_op_d    = rsp_op_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    tick_d      = '0;
    jtag_tms    = 1'b0;
    jtag_tdi    = 1'b0;

    active    = (state_q != S_IDLE) && (state_q != S_RSP);
    step_end  = active && (tick_q == T_LAST);
    last      = (step_q == '0);
    adv       = step_end && last;
    req_ready = !active;
    accept    = req_valid && req_ready;

    // TDO is latched just before TCK rises; it is consumed at step end
    if (active) begin
      tick_d = step_end ? '0 : tick_q + TW'(1);
      if (tick_q == T_LAST_LO) tdo_d = jtag_tdo;
    end

    if (step_end && !last) step_d = step_q - SW'(1);

    unique case (state_q)
      S_TLR: begin
        jtag_tms = !last;
        if (adv) begin
          state_d     = S_IDLE;
          ir_loaded_d = 1'b0;
        end
      end
      S_IDLE: begin
      end
      S_IR_HDR: begin
        jtag_tms = (step_q > SW'(1));
        if (adv) begin
          state_d = S_IR_SHIFT;
          step_d  = SW'(IR_LEN - 1);
        end
      end
      S_IR_SHIFT: begin
        jtag_tms = last;
        jtag_tdi = ir_q[0];
        if (step_end) ir_d = ir_q >> 1;
        if (adv) begin
          state_d = S_IR_TAIL;
          step_d  = SW'(1);
        end
      end
      S_IR_TAIL: begin
        jtag_tms = !last;
        if (adv) begin
          state_d     = S_DR_HDR;
          step_d      = SW'(2);
          ir_loaded_d = 1'b1;
        end
      end
      S_DR_HDR: begin
        jtag_tms = (step_q == SW'(2));
        if (adv) begin
          state_d = S_DR_SHIFT;
          step_d  = SW'(N - 1);
        end
      end
      S_DR_SHIFT: begin
        jtag_tms = last;
        jtag_tdi = sh_q[0];
        if (step_end) sh_d = {tdo_q, sh_q[N-1:1]};
        if (adv) begin
          state_d = S_DR_TAIL;
          step_d  = SW'(1);
        end
      end
      S_DR_TAIL: begin
        jtag_tms = !last;
        if (adv) begin
          state_d    = S_RSP;
          rsp_op_d   = sh_q[1:0];
          rsp_data_d = sh_q[DBITS+1:2];
          rsp_addr_d = sh_q[N-1:DBITS+2];
        end
      end
      S_RSP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_TLR;
      end
    endcase

    // RSP also accepts, so a new scan can start straight after a response
    if (accept) begin
      sh_d = {req_addr, req_data, req_op};
      ir_d = IR_DMI;
      if (IR_CACHE == 0 || !ir_loaded_q) begin
        state_d = S_IR_HDR;
        step_d  = SW'(3);
      end else begin
        state_d = S_DR_HDR;
        step_d  = SW'(2);
      end
    end
  end

  assign jtag_tck  = active && (tick_q >= T_HI);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RSP);
  assign rsp_op    = rsp_op_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;

endmodule
